// File: rtl/lsu_bus_if.sv
// Bundles the core-side request/response handshake and the memory-bus
// signals of the load/store unit into one connection.
interface lsu_bus_if;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  mem_type;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_wen;
   logic [3:0]  bus_wmask;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   // The load/store unit itself
   modport slave (
      input  req_valid, mem_type, addr, wdata, bus_req_ready, bus_rvalid, bus_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             bus_req_valid, bus_addr, bus_wen, bus_wmask, bus_wdata
   );

   // The surrounding core plus memory that drive the unit
   modport master (
      output req_valid, mem_type, addr, wdata, bus_req_ready, bus_rvalid, bus_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             bus_req_valid, bus_addr, bus_wen, bus_wmask, bus_wdata
   );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit: validates a core memory operation, issues one word-aligned
// bus transaction with byte lanes, then returns extended load data or an error.
module lsu_bus #(
   parameter int TIMEOUT = 255
) (
   input logic       clk,
   input logic       rst,
   lsu_bus_if.slave  lsu
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   // One-hot positions inside mem_type
   localparam int SB  = 0;
   localparam int SH  = 1;
   localparam int SW  = 2;
   localparam int LB  = 3;
   localparam int LH  = 4;
   localparam int LW  = 5;
   localparam int LBU = 6;
   localparam int LHU = 7;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_count;
   logic [7:0]     r_type;
   logic [31:0]    r_addr;
   logic [31:0]    r_wdata;
   logic [31:0]    r_rdata;
   logic [1:0]     r_err;

   logic           w_illegal;
   logic           w_misaligned;
   logic           w_timeout;
   logic           w_isStore;
   logic [3:0]     w_wmask;
   logic [31:0]    w_wdata;
   logic [31:0]    w_load;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;

   // Classify the incoming operation: zero or multi-hot type is illegal,
   // otherwise halves need an even address and words a 4-byte aligned one
   always_comb begin
      w_illegal    = (lsu.mem_type == 8'h00) ||
                     ((lsu.mem_type & (lsu.mem_type - 8'h01)) != 8'h00);
      w_misaligned = ((lsu.mem_type[SH] | lsu.mem_type[LH] | lsu.mem_type[LHU]) & lsu.addr[0]) |
                     ((lsu.mem_type[SW] | lsu.mem_type[LW]) & (lsu.addr[1:0] != 2'b00));
   end

   assign w_timeout = (r_count >= TLIM);
   assign w_isStore = |r_type[SW:SB];

   // Byte-lane enables and replicated store data for the captured store
   always_comb begin
      w_wmask = 4'b0000;
      w_wdata = 32'h0000_0000;
      if (r_type[SB]) begin
         w_wmask = 4'b0001 << r_addr[1:0];
         w_wdata = {4{r_wdata[7:0]}};
      end else if (r_type[SH]) begin
         w_wmask = 4'b0011 << r_addr[1:0];
         w_wdata = {2{r_wdata[15:0]}};
      end else if (r_type[SW]) begin
         w_wmask = 4'hF;
         w_wdata = r_wdata;
      end
   end

   // Pick the addressed byte/half out of the returned word and extend it
   always_comb begin
      w_byte = lsu.bus_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_half = lsu.bus_rdata[{r_addr[1], 4'b0000} +: 16];
      w_load = 32'h0000_0000;
      if (r_type[LB]) begin
         w_load = {{24{w_byte[7]}}, w_byte};
      end else if (r_type[LH]) begin
         w_load = {{16{w_half[15]}}, w_half};
      end else if (r_type[LW]) begin
         w_load = lsu.bus_rdata;
      end else if (r_type[LBU]) begin
         w_load = {24'h000000, w_byte};
      end else if (r_type[LHU]) begin
         w_load = {16'h0000, w_half};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decision; a bus response that lands on the last allowed
   // cycle still wins over the timeout
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (lsu.req_valid) begin
               w_next = (w_illegal || w_misaligned) ? RESP : REQ;
            end
         end
         REQ: begin
            if (lsu.bus_req_ready) begin
               w_next = WAIT;
            end else if (w_timeout) begin
               w_next = RESP;
            end
         end
         WAIT: begin
            if (lsu.bus_rvalid || w_timeout) begin
               w_next = RESP;
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Captured request, cycle counter and the response being assembled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_type  <= 8'h00;
         r_addr  <= 32'h0000_0000;
         r_wdata <= 32'h0000_0000;
         r_rdata <= 32'h0000_0000;
         r_err   <= 2'b00;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (lsu.req_valid) begin
                  r_count <= '0;
                  r_rdata <= 32'h0000_0000;
                  if (w_illegal) begin
                     r_err <= 2'b11;
                  end else if (w_misaligned) begin
                     r_err <= 2'b01;
                  end else begin
                     r_err   <= 2'b00;
                     r_type  <= lsu.mem_type;
                     r_addr  <= lsu.addr;
                     r_wdata <= lsu.wdata;
                  end
               end
            end
            REQ: begin
               r_count <= r_count + CW'(1);
               if (!lsu.bus_req_ready && w_timeout) begin
                  r_err <= 2'b10;
               end
            end
            WAIT: begin
               r_count <= r_count + CW'(1);
               if (lsu.bus_rvalid) begin
                  r_rdata <= w_load;
               end else if (w_timeout) begin
                  r_err <= 2'b10;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign lsu.req_ready     = (r_state == IDLE);
   assign lsu.resp_valid    = (r_state == RESP);
   assign lsu.resp_rdata    = (r_state == RESP) ? r_rdata : 32'h0000_0000;
   assign lsu.resp_err      = (r_state == RESP) ? r_err : 2'b00;
   assign lsu.bus_req_valid = (r_state == REQ);
   assign lsu.bus_addr      = (r_state == REQ) ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
   assign lsu.bus_wen       = (r_state == REQ) && w_isStore;
   assign lsu.bus_wmask     = (r_state == REQ) ? w_wmask : 4'b0000;
   assign lsu.bus_wdata     = (r_state == REQ) ? w_wdata : 32'h0000_0000;

endmodule
